// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/compare ops, plus MULU and DIVU
// that iterate one bit per cycle (shift-add multiply, restoring divide).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [CNT_W-1:0] cnt;
  logic             last, b_zero;
  logic [WIDTH-1:0] alu_res, iter_hi, iter_lo;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;

  assign last   = (cnt == CNT_W'(WIDTH-1));
  assign b_zero = (b == '0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) begin
        if (op == OP_MULU)                state_nx = MUL;
        else if (op == OP_DIVU && !b_zero) state_nx = DIV;
      end
      MUL, DIV: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_DIVU: alu_res = '1;
      default: alu_res = '0;
    endcase
  end

  // acc_hi/acc_lo hold {partial product, multiplier} for MUL and
  // {partial remainder, dividend->quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd});
    div_diff = div_sh - {1'b0, opnd};
    iter_hi  = acc_hi;
    iter_lo  = acc_lo;
    if (state == MUL) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == DIV) begin
      iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      iter_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      cnt         <= '0;
      result      <= '0;
      result_hi   <= '0;
      zero_flag   <= 1'b1;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          div_by_zero <= 1'b0;
          cnt         <= '0;
          if (op == OP_MULU) begin
            acc_hi <= '0;
            acc_lo <= b;
            opnd   <= a;
          end else if (op == OP_DIVU && !b_zero) begin
            acc_hi <= '0;
            acc_lo <= a;
            opnd   <= b;
          end else begin
            result      <= alu_res;
            result_hi   <= (op == OP_DIVU) ? a : '0;
            zero_flag   <= (alu_res == '0);
            div_by_zero <= (op == OP_DIVU);
            done        <= 1'b1;
          end
        end
      end else begin
        acc_hi <= iter_hi;
        acc_lo <= iter_lo;
        cnt    <= cnt + 1'b1;
        // Outputs only change on the final iteration so they hold until done.
        if (last) begin
          result    <= iter_lo;
          result_hi <= iter_hi;
          zero_flag <= (iter_lo == '0);
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results are queued at issue and
// compared (values, latency, busy cycles) when done pulses.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    op;
  logic [W-1:0]  a, b, result, result_hi;
  logic          zero_flag, busy, done, div_by_zero;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
    int           bsy;
    int           edge_at;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0, nerr = 0;
  int   edges = 0, busy_cnt = 0;

  seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .zero_flag(zero_flag),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    e.res = '0; e.hi = '0; e.dbz = 1'b0; e.lat = 0; e.bsy = 0; e.edge_at = 0;
    case (o)
      3'b000: e.res = x & y;
      3'b001: e.res = x | y;
      3'b010: e.res = x + y;
      3'b011: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W; e.bsy = W;
      end
      3'b100: e.res = x - y;
      3'b101: begin
        if (y == '0) begin
          e.res = '1; e.hi = x; e.dbz = 1'b1;
        end else begin
          e.res = x / y; e.hi = x % y; e.lat = W; e.bsy = W;
        end
      end
      3'b110: e.res = (x < y) ? 1 : 0;
      default: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
    endcase
    return e;
  endfunction

  // Call at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(o, x, y);
    e.edge_at = edges + 1 + e.lat;
    sb.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("result_hi", result_hi, e.hi);
        check("zero_flag", zero_flag, (e.res == '0));
        check("div_by_zero", div_by_zero, e.dbz);
        check("done_edge", edges, e.edge_at);
        check("busy_cycles", busy_cnt, e.bsy);
        check("busy_with_done", busy, 0);
      end
      busy_cnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_zero_flag", zero_flag, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(3'b010, 32'hFFFF_FFFF, 32'd1);          // ADD wrap, first edge after reset
    issue(3'b111, 32'hFFFF_FFFF, 32'd1);          // SLT back-to-back
    issue(3'b110, 32'hFFFF_FFFF, 32'd1);          // SLTU
    issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    issue(3'b001, 32'hF000_0000, 32'h0000_000F);
    issue(3'b100, 32'd5, 32'd7);
    wait_empty();

    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  // operands scrambled while busy
    op = 3'b000; a = 32'h1234; b = 32'h0;
    wait_empty();
    issue(3'b101, 32'd100, 32'd7);
    wait_empty();
    issue(3'b101, 32'd5, 32'd0);
    issue(3'b100, 32'd9, 32'd9);                  // clears div_by_zero
    wait_empty();

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = (i % 4 == 3) ? '0 : $urandom();
      issue(ro, ra, rb);
      if (model(ro, ra, rb).lat > 0) begin
        repeat (3) @(posedge clk);
        #1 start = 1'b1; op = 3'b010; a = $urandom(); b = $urandom();
        @(posedge clk); #1 start = 1'b0;
      end
      wait_empty();
    end

    // Abort a multiply with reset; the ADD pulse during busy must be ignored.
    issue(3'b011, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    check("abort_result", result, 0);
    check("abort_result_hi", result_hi, 0);
    check("abort_zero_flag", zero_flag, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(3'b010, 32'd3, 32'd4);
    wait_empty();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
